// File: rtl/uart_arb_pkg.sv
// Shared state encoding and default limits for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int UART_ARB_TIMEOUT   = 16384;
    localparam int UART_ARB_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] k;
        valid = |req;
        idx   = '0;
        k     = '0;
        // Scan farthest offset first so the request nearest to ptr is the last to win.
        for (int off = N - 1; off >= 0; off--) begin
            k = IW'((int'(ptr) + off) % N);
            if (req[k]) begin
                idx = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path, with bounded bursts and a tx_done watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = UART_ARB_MAX_BURST,
    parameter int TIMEOUT   = UART_ARB_TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       lock_i,
    input  logic [8*N_REQ-1:0]     data_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [N_REQ-1:0]       err_o,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_done_i,
    output logic                   busy_o,
    output logic [$clog2(N_REQ)-1:0] owner_o
);

    localparam int OW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam int BW = $clog2(MAX_BURST) + 1;

    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [OW-1:0] OWNER_LAST = OW'(N_REQ - 1);

    arb_state_e    state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] owner;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wdog;
    logic          ok;

    logic          pick_valid;
    logic [OW-1:0] pick_idx;
    logic [7:0]    pick_byte;
    logic [7:0]    owner_byte;
    logic          burst_more;

    rr_pick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_byte  = data_i[{pick_idx, 3'b000} +: 8];
    assign owner_byte = data_i[{owner, 3'b000} +: 8];

    // A timed-out byte (ok=0) always ends the burst, as does reaching MAX_BURST bytes.
    assign burst_more = ok && lock_i[owner] && req_i[owner] && (burst_cnt < BURST_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            wdog      <= '0;
            ok        <= 1'b0;
            tx_data_o <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        tx_data_o <= pick_byte;
                        burst_cnt <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (wdog != WDOG_LAST) begin
                        wdog <= wdog + 1'b1;
                    end
                    // tx_done_i takes priority over a watchdog expiring in the same cycle.
                    if (tx_done_i) begin
                        ok    <= 1'b1;
                        state <= DONE;
                    end else if (wdog == WDOG_LAST) begin
                        ok    <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (burst_more) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        tx_data_o <= owner_byte;
                        state     <= START;
                    end else begin
                        ptr   <= (owner == OWNER_LAST) ? '0 : owner + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_o  = '0;
        done_o = '0;
        err_o  = '0;
        if (state == START) begin
            gnt_o[owner] = 1'b1;
        end
        if (state == DONE) begin
            done_o[owner] = ok;
            err_o[owner]  = ~ok;
        end
    end

    assign tx_start_o = (state == START);
    assign busy_o     = (state != IDLE);
    assign owner_o    = owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 2048;
    localparam int OW = $clog2(N);

    logic           clk_i     = 1'b0;
    logic           rst_ni    = 1'b1;
    logic [N-1:0]   req_i     = '0;
    logic [N-1:0]   lock_i    = '0;
    logic [8*N-1:0] data_i    = '0;
    logic           tx_done_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [N-1:0]   err_o;
    logic           tx_start_o;
    logic [7:0]     tx_data_o;
    logic           busy_o;
    logic [OW-1:0]  owner_o;

    int errors = 0;
    int checks = 0;

    // Per-requester byte queues (head/tail indices into a flat array).
    logic [7:0] qdata [N][64];
    int         qhead [N];
    int         qtail [N];

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (tx_done_i),
        .busy_o     (busy_o),
        .owner_o    (owner_o)
    );

    always #50 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req_i     = '0;
        lock_i    = '0;
        data_i    = '0;
        tx_done_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        return N'(1) << k;
    endfunction

    // Round-robin rule: first set request searching upward from p with wrap.
    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_queues();
        for (int k = 0; k < N; k++) begin
            req_i[k]         = (qhead[k] < qtail[k]);
            data_i[8*k +: 8] = (qhead[k] < qtail[k]) ? qdata[k][qhead[k]] : 8'h00;
        end
    endtask

    task automatic test_reset();
        #3 rst_ni = 1'b0;
        #2;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o);
        end
        checks++;
        if (tx_start_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_start: got %b want 0", tx_start_o);
        end
        checks++;
        if ({gnt_o, done_o, err_o} !== '0) begin
            errors++; $display("[TB] FAIL reset_pulses: gnt=%b done=%b err=%b want all 0", gnt_o, done_o, err_o);
        end
        checks++;
        if (owner_o !== '0 || tx_data_o !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_owner_data: owner=%0d data=%h want 0/00", owner_o, tx_data_o);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || tx_start_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle_noreq: busy=%b start=%b want 0/0", busy_o, tx_start_o);
        end
    endtask

    task automatic test_single();
        bit bad;
        do_reset();
        data_i[23:16] = 8'hA5;
        req_i         = 4'b0100;
        tick();
        checks++;
        if (gnt_o !== 4'b0100 || tx_start_o !== 1'b1) begin
            errors++; $display("[TB] FAIL single_gnt: gnt=%b start=%b want 0100/1", gnt_o, tx_start_o);
        end
        checks++;
        if (tx_data_o !== 8'hA5 || owner_o !== 2'd2) begin
            errors++; $display("[TB] FAIL single_data: data=%h owner=%0d want A5/2", tx_data_o, owner_o);
        end
        req_i = '0;
        bad   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx_start_o || gnt_o != 0 || done_o != 0 || err_o != 0 || !busy_o) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("[TB] FAIL single_wait: got activity while waiting, want quiet busy WAIT");
        end
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        checks++;
        if (done_o !== 4'b0100 || err_o !== 4'b0000) begin
            errors++; $display("[TB] FAIL single_done: done=%b err=%b want 0100/0000", done_o, err_o);
        end
        checks++;
        if (tx_data_o !== 8'hA5 || busy_o !== 1'b1) begin
            errors++; $display("[TB] FAIL single_hold: data=%h busy=%b want A5/1", tx_data_o, busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 4'b0000) begin
            errors++; $display("[TB] FAIL single_idle: busy=%b done=%b want 0/0000", busy_o, done_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int g = 0, cnt = 0, wait_cnt = 0;
        bit done_seen = 1'b1;
        do_reset();
        for (int k = 0; k < N; k++) data_i[8*k +: 8] = 8'h10 + 8'(k);
        req_i = '1;
        while (g < 5 && cnt < 200) begin
            tick();
            cnt++;
            tx_done_i = 1'b0;
            if (done_o != 0) begin
                done_seen = 1'b1;
                checks++;
                if (done_o !== onehot(exp_seq[g-1])) begin
                    errors++; $display("[TB] FAIL rr_done: got %b want %b", done_o, onehot(exp_seq[g-1]));
                end
            end
            if (gnt_o != 0) begin
                checks++;
                if (gnt_o !== onehot(exp_seq[g]) || tx_data_o !== 8'h10 + 8'(exp_seq[g]) || !done_seen) begin
                    errors++;
                    $display("[TB] FAIL rr_gnt%0d: gnt=%b data=%h prev_done=%b want %b/%h/1",
                             g, gnt_o, tx_data_o, done_seen, onehot(exp_seq[g]), 8'h10 + 8'(exp_seq[g]));
                end
                done_seen = 1'b0;
                g++;
                wait_cnt = 3;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) tx_done_i = 1'b1;
            end
        end
        checks++;
        if (g != 5) begin
            errors++; $display("[TB] FAIL rr_progress: got %0d grants want 5", g);
        end
    endtask

    task automatic test_burst();
        int         exp_own [7] = '{1, 1, 1, 1, 3, 1, 1};
        logic [7:0] exp_dat [7] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC3, 8'hB4, 8'hB5};
        int         exp_gap [7] = '{0, 1, 1, 1, 2, 2, 1};
        int g = 0, cnt = 0, wait_cnt = 0, last_done = -100;
        do_reset();
        for (int k = 0; k < N; k++) begin
            qhead[k] = 0;
            qtail[k] = 0;
        end
        for (int i = 0; i < 6; i++) qdata[1][i] = 8'hB0 + 8'(i);
        qtail[1]    = 6;
        qdata[3][0] = 8'hC3;
        qtail[3]    = 1;
        lock_i      = 4'b0010;
        drive_queues();
        while (g < 7 && cnt < 300) begin
            tick();
            cnt++;
            tx_done_i = 1'b0;
            if (done_o != 0) last_done = cnt;
            if (gnt_o != 0) begin
                checks++;
                if (gnt_o !== onehot(exp_own[g]) || tx_data_o !== exp_dat[g]) begin
                    errors++;
                    $display("[TB] FAIL burst_gnt%0d: gnt=%b data=%h want %b/%h",
                             g, gnt_o, tx_data_o, onehot(exp_own[g]), exp_dat[g]);
                end
                if (g > 0) begin
                    checks++;
                    if (cnt - last_done != exp_gap[g]) begin
                        errors++; $display("[TB] FAIL burst_gap%0d: got %0d want %0d", g, cnt - last_done, exp_gap[g]);
                    end
                end
                qhead[exp_own[g]]++;
                g++;
                wait_cnt = 2;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) tx_done_i = 1'b1;
            end
            drive_queues();
        end
        checks++;
        if (g != 7) begin
            errors++; $display("[TB] FAIL burst_progress: got %0d grants want 7", g);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit bad = 1'b0;
        do_reset();
        data_i = 32'h0022_1100;
        req_i  = 4'b0110;
        tick();
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++; $display("[TB] FAIL to_gnt: got %b want 0010", gnt_o);
        end
        req_i = 4'b0100;
        while (err_o == 0 && n < TO + 10) begin
            tick();
            n++;
            if (done_o != 0) bad = 1'b1;
        end
        checks++;
        if (n != TO + 1) begin
            errors++; $display("[TB] FAIL to_latency: got %0d want %0d", n, TO + 1);
        end
        checks++;
        if (err_o !== 4'b0010 || bad) begin
            errors++; $display("[TB] FAIL to_err: err=%b done_seen=%b want 0010/0", err_o, bad);
        end
        tick();
        tick();
        checks++;
        if (gnt_o !== 4'b0100 || tx_data_o !== 8'h22) begin
            errors++; $display("[TB] FAIL to_next: gnt=%b data=%h want 0100/22", gnt_o, tx_data_o);
        end
    endtask

    task automatic test_simultaneous();
        bit bad = 1'b0;
        do_reset();
        data_i[7:0] = 8'h5A;
        req_i       = 4'b0001;
        tx_done_i   = 1'b1;
        tick();
        checks++;
        if (gnt_o !== 4'b0001) begin
            errors++; $display("[TB] FAIL sim_gnt: got %b want 0001", gnt_o);
        end
        req_i = '0;
        tick();
        tx_done_i = 1'b0;
        checks++;
        if (done_o !== 4'b0000 || err_o !== 4'b0000 || busy_o !== 1'b1) begin
            errors++; $display("[TB] FAIL sim_stale: done=%b err=%b busy=%b want 0000/0000/1", done_o, err_o, busy_o);
        end
        for (int i = 1; i < TO; i++) begin
            tick();
            if (done_o != 0 || err_o != 0) bad = 1'b1;
        end
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        checks++;
        if (done_o !== 4'b0001 || err_o !== 4'b0000 || bad) begin
            errors++; $display("[TB] FAIL sim_tie: done=%b err=%b early=%b want 0001/0000/0", done_o, err_o, bad);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        data_i[23:16] = 8'h77;
        req_i         = 4'b0100;
        tick();
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++; $display("[TB] FAIL rmw_gnt: got %b want 0100", gnt_o);
        end
        repeat (5) tick();
        #10 rst_ni = 1'b0;
        #1;
        checks++;
        if ({gnt_o, done_o, err_o, tx_start_o, busy_o, owner_o, tx_data_o} !== '0) begin
            errors++;
            $display("[TB] FAIL rmw_async: gnt=%b done=%b err=%b start=%b busy=%b owner=%0d data=%h want all 0",
                     gnt_o, done_o, err_o, tx_start_o, busy_o, owner_o, tx_data_o);
        end
        req_i       = 4'b0101;
        data_i[7:0] = 8'h11;
        tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (gnt_o !== 4'b0001 || tx_data_o !== 8'h11) begin
            errors++; $display("[TB] FAIL rmw_ptr: gnt=%b data=%h want 0001/11", gnt_o, tx_data_o);
        end
    endtask

    task automatic test_random();
        int ptr_m = 0, owner_m = 0, burst_m = 0, exp_owner = 0;
        int cyc = 0, exp_end = -1, done_at = -1, granted = 0, pushed = 0;
        int r, d, n;
        bit model_idle = 1'b1, exp_gnt = 1'b0, exp_ok = 1'b1, cont_m = 1'b0, wait_now;
        logic [N-1:0] prev_req = '0;
        do_reset();
        for (int k = 0; k < N; k++) begin
            qhead[k] = 0;
            qtail[k] = 0;
        end
        while (cyc < 60000 && !(pushed >= 60 && granted >= pushed && model_idle)) begin
            tick();
            cyc++;
            if (exp_gnt) begin
                model_idle = 1'b0;
                exp_owner  = cont_m ? owner_m : rr_model(prev_req, ptr_m);
                if (!cont_m) burst_m = 0;
                checks++;
                if (gnt_o !== onehot(exp_owner) || tx_start_o !== 1'b1) begin
                    errors++; $display("[TB] FAIL rand_gnt@%0d: gnt=%b start=%b want %b/1", cyc, gnt_o, tx_start_o, onehot(exp_owner));
                end
                checks++;
                if (tx_data_o !== qdata[exp_owner][qhead[exp_owner]] || owner_o !== OW'(exp_owner)) begin
                    errors++;
                    $display("[TB] FAIL rand_data@%0d: data=%h owner=%0d want %h/%0d",
                             cyc, tx_data_o, owner_o, qdata[exp_owner][qhead[exp_owner]], exp_owner);
                end
                qhead[exp_owner]++;
                granted++;
                owner_m = exp_owner;
                r = $urandom_range(0, 23);
                if (r == 0) begin
                    done_at = -1;
                    exp_end = cyc + TO + 1;
                    exp_ok  = 1'b0;
                end else if (r == 1) begin
                    done_at = cyc + TO;
                    exp_end = cyc + TO + 1;
                    exp_ok  = 1'b1;
                end else begin
                    d       = $urandom_range(1, 12);
                    done_at = cyc + d;
                    exp_end = done_at + 1;
                    exp_ok  = 1'b1;
                end
            end else begin
                checks++;
                if (gnt_o !== '0 || tx_start_o !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_spurious_gnt@%0d: gnt=%b start=%b want 0/0", cyc, gnt_o, tx_start_o);
                end
            end
            checks++;
            if (cyc == exp_end) begin
                if (done_o !== (exp_ok ? onehot(owner_m) : N'(0)) || err_o !== (exp_ok ? N'(0) : onehot(owner_m))) begin
                    errors++;
                    $display("[TB] FAIL rand_end@%0d: done=%b err=%b want ok=%b owner=%0d", cyc, done_o, err_o, exp_ok, owner_m);
                end
            end else if (done_o !== '0 || err_o !== '0) begin
                errors++; $display("[TB] FAIL rand_spurious_end@%0d: done=%b err=%b want 0/0", cyc, done_o, err_o);
            end
            checks++;
            if (busy_o !== !model_idle) begin
                errors++; $display("[TB] FAIL rand_busy@%0d: got %b want %b", cyc, busy_o, !model_idle);
            end

            // UART side: real tx_done at the chosen cycle, stale pulses outside WAIT.
            wait_now  = !model_idle && !exp_gnt && (cyc != exp_end);
            tx_done_i = 1'b0;
            if (cyc == done_at) tx_done_i = 1'b1;
            else if (!wait_now && $urandom_range(0, 3) == 0) tx_done_i = 1'b1;

            for (int k = 0; k < N; k++) begin
                if (qhead[k] == qtail[k] && pushed < 60 && qtail[k] <= 59 && $urandom_range(0, 19) == 0) begin
                    n = $urandom_range(1, 5);
                    for (int j = 0; j < n; j++) begin
                        qdata[k][qtail[k]] = 8'($urandom);
                        qtail[k]++;
                    end
                    pushed += n;
                end
            end
            lock_i = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_i[k]         = (qhead[k] < qtail[k]) && ($urandom_range(0, 7) != 0);
                data_i[8*k +: 8] = (qhead[k] < qtail[k]) ? qdata[k][qhead[k]] : 8'h00;
            end

            if (cyc == exp_end) begin
                cont_m = exp_ok && lock_i[owner_m] && req_i[owner_m] && (burst_m < MB - 1);
                if (cont_m) begin
                    burst_m++;
                end else begin
                    ptr_m      = (owner_m + 1) % N;
                    model_idle = 1'b1;
                end
                exp_gnt = cont_m;
            end else begin
                cont_m  = 1'b0;
                exp_gnt = model_idle && (req_i != '0);
            end
            prev_req = req_i;
        end
        checks++;
        if (!(pushed >= 60 && granted >= pushed && model_idle)) begin
            errors++; $display("[TB] FAIL rand_progress: granted=%0d pushed=%0d want all delivered", granted, pushed);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
